// File: rtl/vfd_ramp_clk_gen.sv
// vfd_ramp_clk_gen: run-time programmable step clock for the VFD drive.
// The half-period walks toward a requested target one count at a time, and
// start/stop are only ever honoured at half-period boundaries so the PWM and
// sine-table stage downstream never sees a shortened pulse.
module vfd_ramp_clk_gen #(
  parameter int CNT_W        = 16,
  parameter int RAMP_W       = 16,
  parameter int DEFAULT_HALF = 783
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              enable,
  input  logic [CNT_W-1:0]  target_half,
  input  logic              target_valid,
  input  logic [RAMP_W-1:0] ramp_interval,
  output logic              clk_out,
  output logic              tick,
  output logic [CNT_W-1:0]  cur_half,
  output logic              at_target,
  output logic              busy
);

  localparam logic [CNT_W-1:0] DefaultHalf = CNT_W'(DEFAULT_HALF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t             state_q,    state_d;
  logic [CNT_W-1:0]   counter_q,  counter_d;
  logic [RAMP_W-1:0]  ramp_cnt_q, ramp_cnt_d;
  logic               clk_out_q,  clk_out_d;
  logic               tick_q,     tick_d;
  logic [CNT_W-1:0]   cur_half_q, cur_half_d;
  logic [CNT_W-1:0]   tgt_half_q, tgt_half_d;

  logic               toggle;
  logic               on_target;
  logic [RAMP_W:0]    ramp_inc;

  assign on_target = (cur_half_q == tgt_half_q);

  // Register stage: synchronous reset wipes any ramp or stop in progress.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q    <= IDLE;
      counter_q  <= '0;
      ramp_cnt_q <= '0;
      clk_out_q  <= 1'b0;
      tick_q     <= 1'b0;
      cur_half_q <= DefaultHalf;
      tgt_half_q <= DefaultHalf;
    end else begin
      state_q    <= state_d;
      counter_q  <= counter_d;
      ramp_cnt_q <= ramp_cnt_d;
      clk_out_q  <= clk_out_d;
      tick_q     <= tick_d;
      cur_half_q <= cur_half_d;
      tgt_half_q <= tgt_half_d;
    end
  end

  // Next-state logic: half-period counting, edge generation, ramping and start/stop control.
  always_comb begin
    state_d    = state_q;
    counter_d  = counter_q;
    ramp_cnt_d = ramp_cnt_q;
    clk_out_d  = clk_out_q;
    tick_d     = 1'b0;
    cur_half_d = cur_half_q;
    tgt_half_d = target_valid ? target_half : tgt_half_q;
    toggle     = 1'b0;
    ramp_inc   = {1'b0, ramp_cnt_q} + (RAMP_W+1)'(1);

    // The step counter only means something while a ramp is outstanding.
    if (on_target) begin
      ramp_cnt_d = '0;
    end

    case (state_q)
      IDLE: begin
        counter_d = '0;
        clk_out_d = 1'b0;
        if (enable) begin
          state_d = RUN;
        end
      end

      RUN, STOP: begin
        if ((state_q == RUN) && !enable && !clk_out_q) begin
          // Output is already low, so stopping here cannot clip a pulse.
          state_d   = IDLE;
          counter_d = '0;
        end else begin
          // >= rather than == so a freshly shrunk half-period can never be overrun.
          toggle = (counter_q >= cur_half_q);

          if (toggle) begin
            counter_d = '0;
            clk_out_d = ~clk_out_q;
            tick_d    = 1'b1;

            // Ramp steps land on an edge so each half-period is whole.
            if (!on_target) begin
              if (ramp_interval == '0) begin
                cur_half_d = tgt_half_q;
                ramp_cnt_d = '0;
              end else if (ramp_inc >= {1'b0, ramp_interval}) begin
                ramp_cnt_d = '0;
                if (cur_half_q < tgt_half_q) begin
                  cur_half_d = cur_half_q + CNT_W'(1);
                end else begin
                  cur_half_d = cur_half_q - CNT_W'(1);
                end
              end else begin
                ramp_cnt_d = ramp_inc[RAMP_W-1:0];
              end
            end
          end else begin
            counter_d = counter_q + CNT_W'(1);
          end

          // A falling edge while enable is low completes the stop; re-enable
          // resumes without disturbing the half-period in flight.
          if (enable) begin
            state_d = RUN;
          end else if (toggle && clk_out_q) begin
            state_d = IDLE;
          end else begin
            state_d = STOP;
          end
        end
      end

      default: begin
        state_d   = IDLE;
        counter_d = '0;
        clk_out_d = 1'b0;
      end
    endcase
  end

  assign clk_out   = clk_out_q;
  assign tick      = tick_q;
  assign cur_half  = cur_half_q;
  assign at_target = on_target;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_vfd_ramp_clk_gen.sv
// tb_vfd_ramp_clk_gen: directed scenarios followed by randomized traffic,
// all compared every cycle against a countdown-style behavioural model.
module tb_vfd_ramp_clk_gen;

  localparam int CntW        = 16;
  localparam int RampW       = 16;
  localparam int DefaultHalf = 783;

  logic             clkIn = 1'b0;
  logic             reset;
  logic             enable;
  logic [CntW-1:0]  targetHalf;
  logic             targetValid;
  logic [RampW-1:0] rampInterval;
  logic             clkOut;
  logic             tick;
  logic [CntW-1:0]  curHalf;
  logic             atTarget;
  logic             busy;

  int nChecks = 0;
  int nFails  = 0;
  bit checkOn = 1'b0;

  // Reference model state: mode 0 = stopped, 1 = running, 2 = draining the high phase.
  int mMode;
  int mRemain;
  int mCur;
  int mTgt;
  int mSince;
  bit mClk;
  bit mTick;
  int newTgt;
  bit wasHigh;

  vfd_ramp_clk_gen #(
    .CNT_W        (CntW),
    .RAMP_W       (RampW),
    .DEFAULT_HALF (DefaultHalf)
  ) dut (
    .clk_in        (clkIn),
    .reset         (reset),
    .enable        (enable),
    .target_half   (targetHalf),
    .target_valid  (targetValid),
    .ramp_interval (rampInterval),
    .clk_out       (clkOut),
    .tick          (tick),
    .cur_half      (curHalf),
    .at_target     (atTarget),
    .busy          (busy)
  );

  always #5 clkIn = ~clkIn;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one set of inputs (caller sits on a negedge) and advance to the next negedge.
  task automatic applyStimulus(input logic r, input logic en, input logic tv,
                               input int th, input int ri);
    reset        = r;
    enable       = en;
    targetValid  = tv;
    targetHalf   = CntW'(th);
    rampInterval = RampW'(ri);
    @(negedge clkIn);
  endtask

  // Behavioural model: counts down the remainder of each half-period and
  // applies ramp steps on edges, stepping toward the previously held target.
  always @(posedge clkIn) begin
    if (reset) begin
      mMode   = 0;
      mClk    = 1'b0;
      mTick   = 1'b0;
      mCur    = DefaultHalf;
      mTgt    = DefaultHalf;
      mRemain = DefaultHalf;
      mSince  = 0;
    end else begin
      newTgt = targetValid ? int'(targetHalf) : mTgt;
      mTick  = 1'b0;
      if (mCur == mTgt) mSince = 0;
      if (mMode == 0) begin
        if (enable) mMode = 1;
      end else if (mMode == 1 && !enable && !mClk) begin
        mMode = 0;
      end else if (mRemain == 0) begin
        wasHigh = mClk;
        mClk    = !mClk;
        mTick   = 1'b1;
        if (mCur != mTgt) begin
          if (rampInterval == 0) begin
            mCur   = mTgt;
            mSince = 0;
          end else begin
            mSince++;
            if (mSince >= int'(rampInterval)) begin
              mSince = 0;
              mCur   = (mCur < mTgt) ? mCur + 1 : mCur - 1;
            end
          end
        end
        mRemain = mCur;
        if (enable) mMode = 1;
        else        mMode = wasHigh ? 0 : 2;
      end else begin
        mRemain--;
        mMode = enable ? 1 : 2;
      end
      if (mMode == 0) mRemain = mCur;
      mTgt = newTgt;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clkIn) begin
    if (checkOn) begin
      checkOutput("model_clk_out",   32'(clkOut),   32'(mClk));
      checkOutput("model_tick",      32'(tick),     32'(mTick));
      checkOutput("model_cur_half",  32'(curHalf),  32'(mCur));
      checkOutput("model_at_target", 32'(atTarget), 32'(mCur == mTgt));
      checkOutput("model_busy",      32'(busy),     32'(mMode != 0));
    end
  end

  // Watchdog so the run always ends even if a loop bound were mis-sized.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int ticks;
    int guard;
    bit en;
    bit prevReset;
    int ri;

    reset        = 1'b1;
    enable       = 1'b0;
    targetValid  = 1'b0;
    targetHalf   = '0;
    rampInterval = '0;
    @(posedge clkIn);
    checkOn = 1'b1;
    @(negedge clkIn);

    checkOutput("reset_cur_half",  32'(curHalf),  32'd783);
    checkOutput("reset_at_target", 32'(atTarget), 32'd1);
    checkOutput("reset_busy",      32'(busy),     32'd0);
    checkOutput("reset_clk_out",   32'(clkOut),   32'd0);

    // First rise 784 cycles after RUN, then a 1568-cycle period with two ticks.
    applyStimulus(1'b0, 1'b1, 1'b0, 0, 0);
    checkOutput("run_busy", 32'(busy), 32'd1);
    n = 0;
    while (!clkOut && n < 3000) begin
      @(negedge clkIn);
      n++;
    end
    checkOutput("first_rise_cycles", 32'(n), 32'd784);
    n = 0;
    ticks = 0;
    while (n < 4000) begin
      @(negedge clkIn);
      n++;
      if (tick) ticks++;
      if (tick && clkOut) break;
    end
    checkOutput("default_period", 32'(n), 32'd1568);
    checkOutput("ticks_per_period", 32'(ticks), 32'd2);

    // Ramp 783 -> 779 with a step every second toggle.
    applyStimulus(1'b0, 1'b1, 1'b1, 779, 2);
    checkOutput("retarget_clears_at_target", 32'(atTarget), 32'd0);
    n = 0;
    guard = 0;
    while (!atTarget && guard < 10000) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 779, 2);
      guard++;
      if (tick) n++;
    end
    checkOutput("ramp_down_toggles", 32'(n), 32'd8);
    checkOutput("ramp_down_final", 32'(curHalf), 32'd779);

    // Interval 0 jumps straight to 790 at the next toggle; half period 791.
    applyStimulus(1'b0, 1'b1, 1'b1, 790, 0);
    n = 0;
    guard = 0;
    while (curHalf != 16'd790 && guard < 2000) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 790, 0);
      guard++;
      if (tick) n++;
    end
    checkOutput("jump_toggles", 32'(n), 32'd1);
    n = 0;
    do begin
      applyStimulus(1'b0, 1'b1, 1'b0, 790, 0);
      n++;
    end while (!tick && n < 2000);
    checkOutput("jump_half_period", 32'(n), 32'd791);

    // Drop enable right after a rise: high phase must complete in full.
    guard = 0;
    do begin
      applyStimulus(1'b0, 1'b1, 1'b0, 790, 0);
      guard++;
    end while (!(tick && clkOut) && guard < 2000);
    n = 0;
    do begin
      applyStimulus(1'b0, 1'b0, 1'b0, 790, 0);
      n++;
    end while (clkOut && n < 2000);
    checkOutput("stop_high_phase", 32'(n), 32'd791);
    checkOutput("stop_busy_cleared", 32'(busy), 32'd0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b0, 790, 0);
    checkOutput("idle_clk_low", 32'(clkOut), 32'd0);
    checkOutput("idle_cur_kept", 32'(curHalf), 32'd790);

    // Target 0 with interval 0: once reached, clk_out toggles every cycle.
    applyStimulus(1'b0, 1'b1, 1'b1, 0, 0);
    guard = 0;
    while (curHalf != 16'd0 && guard < 2000) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 0, 0);
      guard++;
    end
    ticks = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 0, 0);
      if (tick) ticks++;
    end
    checkOutput("half_zero_ticks", 32'(ticks), 32'd10);

    // Ramp up toward 20, then redirect down to 1 mid-ramp.
    applyStimulus(1'b0, 1'b1, 1'b1, 20, 1);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 1'b0, 20, 1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1, 1);
    guard = 0;
    while (!atTarget && guard < 300) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1, 1);
      guard++;
    end
    checkOutput("redirect_final", 32'(curHalf), 32'd1);

    // Reset asserted mid-STOP discards everything.
    applyStimulus(1'b0, 1'b1, 1'b1, 40, 0);
    guard = 0;
    do begin
      applyStimulus(1'b0, 1'b1, 1'b0, 40, 0);
      guard++;
    end while (!(tick && clkOut && curHalf == 16'd40) && guard < 500);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b0, 40, 0);
    checkOutput("stop_busy", 32'(busy), 32'd1);
    checkOutput("stop_clk_high", 32'(clkOut), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 40, 0);
    checkOutput("midstop_reset_cur", 32'(curHalf), 32'd783);
    checkOutput("midstop_reset_at_target", 32'(atTarget), 32'd1);
    checkOutput("midstop_reset_busy", 32'(busy), 32'd0);
    checkOutput("midstop_reset_clk", 32'(clkOut), 32'd0);

    // Randomized traffic with short half-periods.
    applyStimulus(1'b0, 1'b1, 1'b1, 6, 0);
    en = 1'b1;
    ri = 0;
    prevReset = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (prevReset) begin
        prevReset = 1'b0;
        ri = 0;
        applyStimulus(1'b0, en, 1'b1, $urandom_range(0, 15), ri);
      end else if ($urandom_range(0, 599) == 0) begin
        prevReset = 1'b1;
        applyStimulus(1'b1, en, 1'b0, 0, ri);
      end else begin
        if ($urandom_range(0, 39) == 0) en = !en;
        if ($urandom_range(0, 24) == 0) ri = $urandom_range(0, 3);
        applyStimulus(1'b0, en, ($urandom_range(0, 9) == 0), $urandom_range(0, 15), ri);
      end
    end

    checkOn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
    $finish;
  end

endmodule
